// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses ASCII "<A><op><B>=" commands from a UART byte
// stream into two unsigned 32-bit operands and a 2-bit operator code.
// Handshake: a byte on rx_data is consumed only in a cycle where
// uin_valid=1 (one byte per strobe, no back-pressure). The outputs
// op_a/op_b/op_code are valid in the cycle alu_start is high and hold
// until the next alu_start.
module uart_cmd_decoder #(
    parameter int MAX_DIGITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        uin_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [1:0]  op_code,
    output logic        alu_start,
    output logic        parse_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_A0  = 3'd0,
        S_A   = 3'd1,
        S_B0  = 3'd2,
        S_B   = 3'd3,
        S_ERR = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_a_q, acc_a_d;
    logic [31:0]   acc_b_q, acc_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    opc_q, opc_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [1:0]    op_code_q, op_code_d;
    logic          alu_start_q, alu_start_d;
    logic          parse_err_q, parse_err_d;
    logic          busy_q, busy_d;

    logic          is_digit;
    logic          is_op;
    logic          is_eq;
    logic          is_space;
    logic [1:0]    op_enc;
    logic [3:0]    digit_val;
    logic [31:0]   acc_sel;
    logic [31:0]   acc_next;
    logic          cnt_full;

    // Byte classification and the shared multiply-by-ten accumulator step.
    always_comb begin
        is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_eq     = (rx_data == 8'h3D);
        is_space  = (rx_data == 8'h20);
        digit_val = rx_data[3:0];
        is_op     = 1'b1;
        op_enc    = 2'b00;
        case (rx_data)
            8'h2B:   op_enc = 2'b00;
            8'h2D:   op_enc = 2'b01;
            8'h2A:   op_enc = 2'b10;
            8'h2F:   op_enc = 2'b11;
            default: is_op  = 1'b0;
        endcase
        // Only one operand accumulates at a time, so one adder serves both.
        acc_sel  = (state_q == S_B) ? acc_b_q : acc_a_q;
        acc_next = (acc_sel << 3) + (acc_sel << 1) + {28'd0, digit_val};
        cnt_full = (cnt_q == CW'(MAX_DIGITS));
    end

    // Next-state and next-output computation for the parser FSM.
    always_comb begin
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        cnt_d       = cnt_q;
        opc_d       = opc_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_code_d   = op_code_q;
        alu_start_d = 1'b0;
        parse_err_d = 1'b0;

        if (uin_valid && !is_space) begin
            case (state_q)
                S_A0: begin
                    if (is_digit) begin
                        acc_a_d = {28'd0, digit_val};
                        cnt_d   = CW'(1);
                        state_d = S_A;
                    end else if (!is_eq) begin
                        state_d = S_ERR;
                    end
                end
                S_A: begin
                    if (is_digit) begin
                        if (cnt_full) begin
                            state_d = S_ERR;
                        end else begin
                            acc_a_d = acc_next;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else if (is_op) begin
                        opc_d   = op_enc;
                        cnt_d   = '0;
                        state_d = S_B0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_B0: begin
                    if (is_digit) begin
                        acc_b_d = {28'd0, digit_val};
                        cnt_d   = CW'(1);
                        state_d = S_B;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        if (cnt_full) begin
                            state_d = S_ERR;
                        end else begin
                            acc_b_d = acc_next;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else if (is_eq) begin
                        op_a_d      = acc_a_q;
                        op_b_d      = acc_b_q;
                        op_code_d   = opc_q;
                        alu_start_d = 1'b1;
                        state_d     = S_A0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    // Everything up to the next '=' is discarded.
                    if (is_eq) begin
                        state_d = S_A0;
                    end
                end
                default: state_d = S_A0;
            endcase
        end

        // Pulse only on entry so repeated garbage while in ERR stays quiet.
        if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            parse_err_d = 1'b1;
        end

        busy_d = (state_d == S_A) || (state_d == S_B0) || (state_d == S_B);
    end

    // State, accumulator and output registers; reset overrides any byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            cnt_q       <= '0;
            opc_q       <= 2'b00;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= 2'b00;
            alu_start_q <= 1'b0;
            parse_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            cnt_q       <= cnt_d;
            opc_q       <= opc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_code_q   <= op_code_d;
            alu_start_q <= alu_start_d;
            parse_err_q <= parse_err_d;
            busy_q      <= busy_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_code   = op_code_q;
    assign alu_start = alu_start_q;
    assign parse_err = parse_err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed command strings followed by a random
// byte stream, each compared against a string-level reference parser.
module tb_uart_cmd_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        uin_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_code;
    logic        alu_start;
    logic        parse_err;
    logic        busy;
    logic [2:0]  dbg_state;

    uart_cmd_decoder #(.MAX_DIGITS(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .uin_valid (uin_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_code   (op_code),
        .alu_start (alu_start),
        .parse_err (parse_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;
    int n_errs   = 0;

    // Reference model state: text of the command so far, plus error mode.
    logic [7:0]  cmd_q[$];
    bit          in_err;
    logic [31:0] exp_a, exp_b;
    logic [1:0]  exp_op;
    logic        exp_start, exp_err, exp_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic bit is_opc(input logic [7:0] b);
        return (b == "+") || (b == "-") || (b == "*") || (b == "/");
    endfunction

    // 0 = not a prefix of a legal command, 1 = legal prefix, 2 = complete.
    function automatic int classify();
        int i, na, nb, n;
        n = cmd_q.size();
        i = 0; na = 0; nb = 0;
        while (i < n && is_dig(cmd_q[i])) begin na++; i++; end
        if (na > 9) return 0;
        if (i == n) return 1;
        if (na == 0 || !is_opc(cmd_q[i])) return 0;
        i++;
        if (i == n) return 1;
        while (i < n && is_dig(cmd_q[i])) begin nb++; i++; end
        if (nb > 9) return 0;
        if (i == n) return 1;
        if (nb == 0 || cmd_q[i] != "=") return 0;
        return 2;
    endfunction

    // Evaluate a complete command text into operands and operator.
    task automatic evaluate();
        int i;
        logic [31:0] a, b;
        a = 0; b = 0; i = 0;
        while (is_dig(cmd_q[i])) begin a = a * 10 + 32'(cmd_q[i] - 8'h30); i++; end
        case (cmd_q[i])
            "+": exp_op = 2'd0;
            "-": exp_op = 2'd1;
            "*": exp_op = 2'd2;
            default: exp_op = 2'd3;
        endcase
        i++;
        while (is_dig(cmd_q[i])) begin b = b * 10 + 32'(cmd_q[i] - 8'h30); i++; end
        exp_a = a;
        exp_b = b;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int c;
        exp_start = 1'b0;
        exp_err   = 1'b0;
        if (b != 8'h20) begin
            if (in_err) begin
                if (b == "=") in_err = 1'b0;
            end else if (!(b == "=" && cmd_q.size() == 0)) begin
                cmd_q.push_back(b);
                c = classify();
                if (c == 0) begin
                    exp_err = 1'b1;
                    in_err  = 1'b1;
                    cmd_q.delete();
                end else if (c == 2) begin
                    evaluate();
                    exp_start = 1'b1;
                    cmd_q.delete();
                end
            end
        end
        exp_busy = (cmd_q.size() != 0);
    endtask

    task automatic model_reset();
        cmd_q.delete();
        in_err    = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        exp_op    = 2'b00;
        exp_start = 1'b0;
        exp_err   = 1'b0;
        exp_busy  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".alu_start"}, {31'd0, alu_start}, {31'd0, exp_start});
        chk({tag, ".parse_err"}, {31'd0, parse_err}, {31'd0, exp_err});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
        chk({tag, ".op_a"}, op_a, exp_a);
        chk({tag, ".op_b"}, op_b, exp_b);
        chk({tag, ".op_code"}, {30'd0, op_code}, {30'd0, exp_op});
        if (alu_start) n_starts++;
        if (parse_err) n_errs++;
    endtask

    // Called at a negedge: drive one byte, check the response one edge later,
    // then idle for gap cycles checking that pulses do not linger.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data   = b;
        uin_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        uin_valid = 1'b0;
        rx_data   = $urandom_range(0, 255);
        check_outputs("byte");
        exp_start = 1'b0;
        exp_err   = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_outputs("gap");
        end
    endtask

    task automatic send_str(input string s, input int max_gap);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_byte(b, $urandom_range(0, max_gap));
        end
    endtask

    // Check the number of pulses seen since the counters were last cleared.
    task automatic chk_counts(input string tag, input int starts, input int errs);
        chk({tag, ".starts"}, 32'(n_starts), 32'(starts));
        chk({tag, ".errs"}, 32'(n_errs), 32'(errs));
        n_starts = 0;
        n_errs   = 0;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        rst       = 1'b1;
        uin_valid = 1'b0;
        rx_data   = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        chk("reset.state", {29'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        n_starts = 0; n_errs = 0;

        // Basic add.
        send_str("12+34=", 0);
        chk_counts("add", 1, 0);
        chk("add.op_a", op_a, 32'd12);

        // Spaces and every operator.
        send_str(" 7 * 6 =", 1);
        chk("mul.op_code", {30'd0, op_code}, 32'd2);
        send_str("100/4=", 0);
        send_str("9-3=", 2);
        chk_counts("ops", 3, 0);

        // Largest operand, then a tenth digit.
        send_str("999999999+1=", 0);
        chk("max.op_a", op_a, 32'h3B9AC9FF);
        send_str("1234567890+1=", 1);
        send_str("2+2=", 0);
        chk_counts("overflow", 2, 1);

        // Syntax errors and resynchronisation.
        send_str("1a", 0);
        send_str("=", 0);
        send_str("+5=", 0);
        send_str("3+=", 0);
        send_str("xx9+*", 1);
        send_str("5+5=", 0);
        chk_counts("syntax", 0, 3);
        send_str("6+6=", 0);
        chk_counts("resync", 1, 0);

        // Reset in mid-command, with a byte presented during reset.
        send_str("45+", 1);
        rst       = 1'b1;
        uin_valid = 1'b1;
        rx_data   = "7";
        model_reset();
        @(negedge clk);
        check_outputs("midrst");
        rst       = 1'b0;
        uin_valid = 1'b0;
        n_starts = 0; n_errs = 0;
        send_str("8*2=", 0);
        chk_counts("midrst", 1, 0);

        // Gapped bytes, then an immediately following command.
        send_str("5/0=", 3);
        send_str("1+1=", 0);
        chk_counts("gapped", 2, 0);

        // Random byte stream weighted toward well-formed commands.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = 8'(8'h30 + $urandom_range(0, 9));
            else if (r < 67) begin
                case ($urandom_range(0, 3))
                    0: b = "+";
                    1: b = "-";
                    2: b = "*";
                    default: b = "/";
                endcase
            end
            else if (r < 78) b = "=";
            else if (r < 86) b = 8'h20;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
